i2c_reg_bridge: RTL and testbench



---
 rtl/i2c_reg_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_reg_bridge.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bridge.sv
// i2c_reg_bridge: I2C target front end that turns I2C write/read transactions
// into single-cycle register bus accesses for led_controller.
//
// Ports:
//   clk_400K   system clock
//   reset      synchronous, active-high reset
//   scl_in     raw SCL pad input (asynchronous)
//   sda_in     raw SDA pad input (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   bus_addr   register address (holds between accesses)
//   bus_wdata  register write data (holds between accesses)
//   bus_rdata  register read data from led_controller
//   bus_w_en   one-cycle write strobe
//   bus_r_en   one-cycle read strobe
//   busy       high from an address-matched START until STOP or abort
module i2c_reg_bridge #(
    parameter logic [6:0]  DEV_ADDR  = 7'h62,
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned NUM_REGS  = 9
) (
    input  logic                 clk_400K,
    input  logic                 reset,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 sda_oe,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [DATA_BITS-1:0] bus_wdata,
    input  logic [DATA_BITS-1:0] bus_rdata,
    output logic                 bus_w_en,
    output logic                 bus_r_en,
    output logic                 busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, WDATA, WDATA_ACK,
        RFETCH, RDATA, RACK, IGNORE
    } state_t;

    state_t               state;
    logic [1:0]           scl_sync, sda_sync;
    logic                 scl_prev, sda_prev;
    logic                 scl_s, sda_s;
    logic                 scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift, byte_in;
    logic [ADDR_BITS-1:0] pointer, rd_ptr;
    logic                 ai, rd_mode, ack_owed, fetch_step, wr_valid;
    logic [1:0]           wr_step;

    function automatic logic [ADDR_BITS-1:0] ptr_inc(input logic [ADDR_BITS-1:0] p);
        return (p == ADDR_BITS'(NUM_REGS - 1)) ? '0 : p + ADDR_BITS'(1);
    endfunction

    function automatic logic ptr_valid(input logic [ADDR_BITS-1:0] p);
        return 32'(p) < NUM_REGS;
    endfunction

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    assign byte_in   = {shift[DATA_BITS-2:0], sda_s};
    assign rd_ptr    = ai ? ptr_inc(pointer) : pointer;

    // Synchronisers reset to the idle-bus level so reset release never looks like START.
    always_ff @(posedge clk_400K) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    always_ff @(posedge clk_400K) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            pointer    <= '0;
            ai         <= 1'b0;
            rd_mode    <= 1'b0;
            ack_owed   <= 1'b0;
            fetch_step <= 1'b0;
            wr_valid   <= 1'b0;
            wr_step    <= '0;
            sda_oe     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_w_en   <= 1'b0;
            bus_r_en   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Strobes default low so each is exactly one cycle even if a
            // START/STOP interrupts the sequence that raised it.
            bus_w_en <= 1'b0;
            bus_r_en <= 1'b0;

            // Write sequence: addr/data latched at N, strobe at N+1, pointer at N+2.
            case (wr_step)
                2'd1: begin
                    bus_w_en <= wr_valid;
                    wr_step  <= 2'd2;
                end
                2'd2: begin
                    if (ai) pointer <= ptr_inc(pointer);
                    wr_step <= 2'd0;
                end
                default: ;
            endcase

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (byte_in[DATA_BITS-1:1] == DEV_ADDR) begin
                                busy    <= 1'b1;
                                rd_mode <= byte_in[0];
                                if (byte_in[0]) begin
                                    // Fetch runs inside the high phase, ahead of the ACK fall.
                                    bus_addr   <= pointer;
                                    fetch_step <= 1'b0;
                                    ack_owed   <= 1'b1;
                                    state      <= RFETCH;
                                end else begin
                                    state <= ADDR_ACK;
                                end
                            end else begin
                                busy  <= 1'b0;
                                state <= IGNORE;
                            end
                        end
                    end
                    // First fall after the byte drives ACK; the next one ends it.
                    ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rd_mode) begin
                            sda_oe  <= ~shift[DATA_BITS-1];
                            shift   <= {shift[DATA_BITS-2:0], 1'b0};
                            bit_cnt <= 4'd1;
                            state   <= RDATA;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= CTRL;
                        end
                    end
                    CTRL: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ai      <= byte_in[DATA_BITS-1];
                            pointer <= byte_in[ADDR_BITS-1:0];
                            state   <= CTRL_ACK;
                        end
                    end
                    CTRL_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WDATA;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bus_addr  <= pointer;
                            bus_wdata <= byte_in;
                            wr_valid  <= ptr_valid(pointer);
                            wr_step   <= 2'd1;
                            state     <= WDATA_ACK;
                        end
                    end
                    RFETCH: begin
                        if (!fetch_step) begin
                            bus_r_en   <= 1'b1;
                            fetch_step <= 1'b1;
                        end else begin
                            shift      <= ptr_valid(bus_addr) ? bus_rdata : '0;
                            fetch_step <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= ack_owed ? ADDR_ACK : RDATA;
                        end
                    end
                    RDATA: if (scl_fall) begin
                        if (bit_cnt < 4'd8) begin
                            sda_oe  <= ~shift[DATA_BITS-1];
                            shift   <= {shift[DATA_BITS-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= RACK;
                        end
                    end
                    RACK: if (scl_rise) begin
                        if (!sda_s) begin
                            pointer    <= rd_ptr;
                            bus_addr   <= rd_ptr;
                            fetch_step <= 1'b0;
                            ack_owed   <= 1'b0;
                            state      <= RFETCH;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// tb_i2c_reg_bridge: bench for i2c_reg_bridge. Acts as the I2C master and as
// the register file on the bus side; expectations come from a transaction-level
// model of the pointer/auto-increment rules and a register array.
module tb_i2c_reg_bridge;
    localparam int Q    = 4;   // quarter SCL period in clocks
    localparam int NREG = 9;
    localparam logic [6:0] DEV = 7'h62;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus, sda_oe, bus_w_en, bus_r_en, busy;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic [7:0] slave_mem [16];

    assign sda_bus   = sda_m & ~sda_oe;
    assign bus_rdata = slave_mem[bus_addr];
    always #5 clk = ~clk;

    i2c_reg_bridge #(
        .DEV_ADDR(7'h62), .ADDR_BITS(4), .DATA_BITS(8), .NUM_REGS(9)
    ) dut (
        .clk_400K(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_w_en(bus_w_en), .bus_r_en(bus_r_en),
        .busy(busy)
    );

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic       stable;
    } wr_t;

    wr_t        wr_q[$];
    logic [3:0] rd_q[$];
    logic [7:0] rbytes[$];
    logic [7:0] tx_data[$];
    int         overlap = 0;
    logic [3:0] prev_addr;
    logic [7:0] prev_wdata;

    // Register-file side: applies writes, logs strobes, tracks setup of addr/data.
    always @(posedge clk) begin
        if (bus_w_en) begin
            wr_q.push_back('{bus_addr, bus_wdata,
                             (prev_addr == bus_addr) && (prev_wdata == bus_wdata)});
            slave_mem[bus_addr] = bus_wdata;
        end
        if (bus_r_en) rd_q.push_back(bus_addr);
        if (bus_w_en && bus_r_en) overlap++;
        prev_addr  = bus_addr;
        prev_wdata = bus_wdata;
    end

    // Reference model state
    logic [3:0] m_ptr;
    logic       m_ai;
    logic [7:0] m_mem [16];

    function automatic logic [3:0] m_inc(input logic [3:0] p);
        return (int'(p) == NREG - 1) ? 4'd0 : p + 4'd1;
    endfunction

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(2*Q);
        sda_m = 1'b0; clks(2*Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b1; clks(2*Q);
        sda_m = 1'b1; clks(2*Q);
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_m = b;    clks(Q);
        scl_m = 1'b1; clks(Q);
        s = sda_bus;  clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(nack, s);
    endtask

    // Full write transaction: START, dev, ctrl, tx_data..., STOP.
    task automatic do_write(input logic [7:0] dev, input logic [7:0] ctrl,
                            input string tag, output int n_ack);
        logic a;
        logic match;
        wr_t  exp_q[$];
        match = (dev[7:1] == DEV) && !dev[0];
        n_ack = 0;
        wr_q.delete();
        rd_q.delete();
        i2c_start;
        write_byte(dev, a);  n_ack += int'(a);
        chk({tag, "/ack_dev"}, a, match);
        chk({tag, "/busy"}, busy, match);
        write_byte(ctrl, a); n_ack += int'(a);
        chk({tag, "/ack_ctrl"}, a, match);
        if (match) begin
            m_ai  = ctrl[7];
            m_ptr = ctrl[3:0];
        end
        foreach (tx_data[i]) begin
            write_byte(tx_data[i], a); n_ack += int'(a);
            chk({tag, "/ack_data"}, a, match);
            if (match) begin
                if (int'(m_ptr) < NREG) begin
                    exp_q.push_back('{m_ptr, tx_data[i], 1'b1});
                    m_mem[m_ptr] = tx_data[i];
                end
                if (m_ai) m_ptr = m_inc(m_ptr);
            end
        end
        i2c_stop;
        chk({tag, "/busy_after_stop"}, busy, 0);
        chk({tag, "/sda_oe_idle"}, sda_oe, 0);
        chk({tag, "/n_writes"}, wr_q.size(), exp_q.size());
        chk({tag, "/n_reads"}, rd_q.size(), 0);
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            chk({tag, "/w_addr"}, wr_q[i].a, exp_q[i].a);
            chk({tag, "/w_data"}, wr_q[i].d, exp_q[i].d);
            chk({tag, "/w_setup"}, wr_q[i].stable, 1);
        end
    endtask

    // Read transaction of n bytes; optionally sets the pointer first with a Sr.
    task automatic do_read(input int n, input bit use_ctrl, input logic [7:0] ctrl,
                           input string tag);
        logic       a;
        logic [7:0] b, exp;
        logic [3:0] exp_rd[$];
        bit         all_valid;
        all_valid = 1'b1;
        wr_q.delete();
        rd_q.delete();
        rbytes.delete();
        i2c_start;
        if (use_ctrl) begin
            write_byte({DEV, 1'b0}, a); chk({tag, "/ack_wdev"}, a, 1);
            write_byte(ctrl, a);        chk({tag, "/ack_ctrl"}, a, 1);
            m_ai  = ctrl[7];
            m_ptr = ctrl[3:0];
            i2c_start;
        end
        write_byte({DEV, 1'b1}, a);
        chk({tag, "/ack_rdev"}, a, 1);
        for (int k = 0; k < n; k++) begin
            exp = (int'(m_ptr) < NREG) ? m_mem[m_ptr] : 8'h00;
            exp_rd.push_back(m_ptr);
            if (int'(m_ptr) >= NREG) all_valid = 1'b0;
            read_byte(k == n - 1, b);
            rbytes.push_back(b);
            chk({tag, "/rbyte"}, b, exp);
            if (k < n - 1 && m_ai) m_ptr = m_inc(m_ptr);
        end
        chk({tag, "/busy"}, busy, 1);
        chk({tag, "/sda_released"}, sda_oe, 0);
        i2c_stop;
        chk({tag, "/busy_after_stop"}, busy, 0);
        chk({tag, "/n_writes"}, wr_q.size(), 0);
        if (all_valid) begin
            chk({tag, "/n_reads"}, rd_q.size(), exp_rd.size());
            foreach (exp_rd[i]) if (i < rd_q.size())
                chk({tag, "/r_addr"}, rd_q[i], exp_rd[i]);
        end
    endtask

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ctrl;
        logic [7:0] data;
        int         exp_acks;
        int         exp_n;
        logic [3:0] exp_a;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        int         nack;
        logic       a;
        logic       s;
        logic [7:0] d8;

        vecs[0] = '{8'hC4, 8'h02, 8'h40, 3, 1, 4'd2, 8'h40};
        vecs[1] = '{8'hC4, 8'h00, 8'h5A, 3, 1, 4'd0, 8'h5A};
        vecs[2] = '{8'hC4, 8'h08, 8'h33, 3, 1, 4'd8, 8'h33};
        vecs[3] = '{8'hC4, 8'h09, 8'h77, 3, 0, 4'd0, 8'h00};
        vecs[4] = '{8'hC4, 8'h0F, 8'h78, 3, 0, 4'd0, 8'h00};
        vecs[5] = '{8'hA0, 8'h02, 8'h11, 0, 0, 4'd0, 8'h00};
        vecs[6] = '{8'hC4, 8'h73, 8'h9C, 3, 1, 4'd3, 8'h9C};

        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 8'($urandom);
            m_mem[i]     = slave_mem[i];
        end
        m_ptr = '0;
        m_ai  = 1'b0;

        reset = 1'b1;
        clks(4);
        chk("rst/sda_oe", sda_oe, 0);
        chk("rst/bus_addr", bus_addr, 0);
        chk("rst/bus_wdata", bus_wdata, 0);
        chk("rst/bus_w_en", bus_w_en, 0);
        chk("rst/bus_r_en", bus_r_en, 0);
        chk("rst/busy", busy, 0);
        reset = 1'b0;
        clks(4);

        // Single-byte write vectors
        foreach (vecs[i]) begin
            tx_data.delete();
            tx_data.push_back(vecs[i].data);
            do_write(vecs[i].dev, vecs[i].ctrl, $sformatf("vec%0d", i), nack);
            chk($sformatf("vec%0d/acks", i), nack, vecs[i].exp_acks);
            chk($sformatf("vec%0d/nw", i), wr_q.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0 && wr_q.size() > 0) begin
                chk($sformatf("vec%0d/addr", i), wr_q[0].a, vecs[i].exp_a);
                chk($sformatf("vec%0d/data", i), wr_q[0].d, vecs[i].exp_d);
            end
        end

        // Auto-increment burst, then wrap from the last register
        tx_data.delete();
        tx_data.push_back(8'h40); tx_data.push_back(8'h80);
        tx_data.push_back(8'hC0); tx_data.push_back(8'hFF);
        do_write(8'hC4, 8'h82, "burst", nack);
        for (int i = 0; i < 4; i++)
            if (i < wr_q.size()) chk("burst/addr", wr_q[i].a, 4'(2 + i));
        tx_data.delete();
        tx_data.push_back(8'h11); tx_data.push_back(8'h22);
        do_write(8'hC4, 8'h88, "wrap", nack);
        if (wr_q.size() == 2) begin
            chk("wrap/addr0", wr_q[0].a, 4'd8);
            chk("wrap/addr1", wr_q[1].a, 4'd0);
        end else begin
            chk("wrap/n", wr_q.size(), 2);
        end

        // Read with repeated START and auto-increment
        slave_mem[5] = 8'hFF; m_mem[5] = 8'hFF;
        slave_mem[6] = 8'h12; m_mem[6] = 8'h12;
        slave_mem[7] = 8'h34; m_mem[7] = 8'h34;
        do_read(3, 1'b1, 8'h85, "rd_sr");
        if (rbytes.size() == 3) begin
            chk("rd_sr/b0", rbytes[0], 8'hFF);
            chk("rd_sr/b1", rbytes[1], 8'h12);
            chk("rd_sr/b2", rbytes[2], 8'h34);
        end
        if (rd_q.size() == 3) chk("rd_sr/last_raddr", rd_q[2], 4'd7);

        // STOP after 5 data bits: byte discarded, next write works
        wr_q.delete();
        i2c_start;
        write_byte(8'hC4, a);
        write_byte(8'h03, a);
        m_ptr = 4'd3;
        m_ai  = 1'b0;
        d8 = 8'hF0;
        for (int i = 7; i >= 3; i--) send_bit(d8[i], s);
        i2c_stop;
        chk("abort/n_writes", wr_q.size(), 0);
        chk("abort/busy", busy, 0);
        chk("abort/sda_oe", sda_oe, 0);
        tx_data.delete();
        tx_data.push_back(8'h66);
        do_write(8'hC4, 8'h04, "after_abort", nack);
        if (wr_q.size() == 1) chk("after_abort/addr", wr_q[0].a, 4'd4);

        // Reset during RDATA while driving SDA low
        slave_mem[0] = 8'hA5; m_mem[0] = 8'hA5;
        slave_mem[3] = 8'h3C; m_mem[3] = 8'h3C;
        i2c_start;
        write_byte(8'hC4, a);
        write_byte(8'h83, a);
        i2c_start;
        write_byte(8'hC5, a);
        chk("rstmid/ack", a, 1);
        chk("rstmid/driving", sda_oe, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmid/sda_oe", sda_oe, 0);
        chk("rstmid/busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        m_ptr = '0;
        m_ai  = 1'b0;
        clks(2);
        i2c_stop;
        do_read(2, 1'b0, 8'h00, "rstmid_ptr0");
        do_read(1, 1'b1, 8'h00, "rstmid_mode");
        if (rbytes.size() == 1) chk("rstmid/mode", rbytes[0], 8'hA5);

        // Randomized transactions against the model
        for (int it = 0; it < 24; it++) begin
            int kind;
            kind = int'($urandom_range(0, 4));
            case (kind)
                0, 1: begin
                    tx_data.delete();
                    repeat ($urandom_range(1, 4)) tx_data.push_back(8'($urandom));
                    do_write(8'hC4, 8'($urandom_range(0, 255)), "rnd_w", nack);
                end
                2: do_read(int'($urandom_range(1, 3)), 1'b1, 8'($urandom_range(0, 255)), "rnd_rc");
                3: do_read(int'($urandom_range(1, 3)), 1'b0, 8'h00, "rnd_r");
                default: begin
                    tx_data.delete();
                    tx_data.push_back(8'($urandom));
                    do_write({DEV ^ 7'($urandom_range(1, 127)), 1'b0},
                             8'($urandom_range(0, 255)), "rnd_bad", nack);
                    chk("rnd_bad/acks", nack, 0);
                end
            endcase
        end

        chk("strobe_exclusive", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
